// File: rtl/mux_nch_reg_if.sv
// Bundle of the stream signals around mux_nch_reg.
//   mode      : 0 = explicit select via sel, 1 = round-robin among valid inputs
//   sel       : channel index used when mode = 0
//   in_data   : packed inputs, channel i at in_data[i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational, at most one bit set)
//   out_data  : registered selected data
//   out_chan  : index of the channel that supplied out_data
//   out_valid : out_data / out_chan hold a valid beat
//   out_ready : consumer accepts the beat
// master = producers plus consumer (the environment); slave = the mux itself.
interface mux_nch_reg_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_nch_reg.sv
// N-channel registered stream multiplexer with valid/ready on both sides.
// One input channel is granted per cycle, either by explicit index (mode = 0)
// or round-robin starting from a rotating pointer (mode = 1). The granted beat
// is captured in a single output holding register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_nch_reg_if slave modport (selection, input streams, output stream)
// Only out_ready/mode/sel/in_valid reach in_ready combinationally; every out_*
// signal comes straight from a flop.
module mux_nch_reg #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input logic          clk,
    input logic          rst_n,
    mux_nch_reg_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_chan_q;
    logic                out_valid_q;
    logic [SEL_W-1:0]    ptr_q;

    logic                load_en;
    logic [SEL_W-1:0]    grant;
    logic                grant_valid;
    logic [CHANNELS-1:0] ready;
    logic                xfer;
    logic [WIDTH-1:0]    grant_data;
    logic [SEL_W-1:0]    ptr_next;

    // Output register may take a new beat when empty or being drained this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (!bus.mode) begin
            // Out-of-range indices exist only for non-power-of-2 channel counts.
            if (32'(bus.sel) < CHANNELS) begin
                grant       = bus.sel;
                grant_valid = 1'b1;
            end
        end else begin
            // First valid channel at or after ptr, wrapping modulo CHANNELS.
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (!grant_valid && bus.in_valid[SEL_W'(idx)]) begin
                    grant       = SEL_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready      = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ready[i] = load_en && grant_valid && (grant == SEL_W'(i));
            if (grant == SEL_W'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer     = |(ready & bus.in_valid);
    assign ptr_next = (32'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_data_q  <= grant_data;
                out_chan_q  <= grant;
                out_valid_q <= 1'b1;
                ptr_q       <= ptr_next;
            end else begin
                // Bubble: data and channel keep their last values.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_nch_reg.sv
// Self-checking bench for mux_nch_reg: a 4-channel instance for the main
// scenarios and randomized traffic against a queue-free behavioural model, and
// a 3-channel instance for out-of-range select and pointer wrap.
module tb_mux_nch_reg;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    mux_nch_reg_if #(.WIDTH(8), .CHANNELS(4)) b4 ();
    mux_nch_reg_if #(.WIDTH(8), .CHANNELS(3)) b3 ();

    mux_nch_reg #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    mux_nch_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state for the 4-channel instance.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_chan;
    int       m_ptr;

    // Granted channel under the selection rules, -1 when nothing is granted.
    function automatic int m_grant();
        if (b4.mode == 1'b0) begin
            return (int'(b4.sel) < 4) ? int'(b4.sel) : -1;
        end
        for (int k = 0; k < 4; k++) begin
            if (b4.in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        g = m_grant();
        if ((!m_valid || b4.out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int g;
        g = m_grant();
        if (!m_valid || b4.out_ready) begin
            if (g >= 0 && b4.in_valid[g]) begin
                m_valid = 1'b1;
                m_data  = b4.in_data[g*8 +: 8];
                m_chan  = g;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 8'h00 || b4.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: got v=%0b d=%h c=%0d want v=0 d=00 c=0",
                     b4.out_valid, b4.out_data, b4.out_chan);
        end
        tick();
        rst_n = 1'b1;
        b4.mode = 1'b0; b4.sel = 2'd1; b4.in_valid = 4'b0010;
        b4.in_data = 32'h00007700; b4.out_ready = 1'b0;
        tick();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h77) begin
            errors++;
            $display("FAIL reset_preload: got v=%0b d=%h want v=1 d=77",
                     b4.out_valid, b4.out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 8'h00 || b4.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: got v=%0b d=%h c=%0d want v=0 d=00 c=0",
                     b4.out_valid, b4.out_data, b4.out_chan);
        end
        tick();
        rst_n = 1'b1;
        b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        #1;
        checks++;
        if (b4.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_rr_ready: got %b want 0001", b4.in_ready);
        end
        tick();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_rr_chan: got v=%0b c=%0d want v=1 c=0",
                     b4.out_valid, b4.out_chan);
        end
    endtask

    task automatic test_explicit();
        do_reset();
        b4.mode = 1'b0; b4.sel = 2'd2; b4.in_valid = 4'b0100;
        b4.in_data = 32'h00A50000; b4.out_ready = 1'b1;
        #1;
        checks++;
        if (b4.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL explicit_ready: got %b want 0100", b4.in_ready);
        end
        tick();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== 8'hA5 || b4.out_chan !== 2'd2) begin
            errors++;
            $display("FAIL explicit_beat: got v=%0b d=%h c=%0d want v=1 d=a5 c=2",
                     b4.out_valid, b4.out_data, b4.out_chan);
        end
        b4.sel = 2'd3;
        #1;
        checks++;
        if (b4.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL explicit_ready_no_valid: got %b want 1000", b4.in_ready);
        end
        tick();
        checks++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 8'hA5 || b4.out_chan !== 2'd2) begin
            errors++;
            $display("FAIL explicit_bubble: got v=%0b d=%h c=%0d want v=0 d=a5 c=2",
                     b4.out_valid, b4.out_data, b4.out_chan);
        end
    endtask

    task automatic test_rr_fair();
        do_reset();
        b4.mode = 1'b1; b4.in_valid = 4'b1111;
        b4.in_data = 32'h13121110; b4.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (b4.out_valid !== 1'b1 || b4.out_chan !== 2'(k % 4) ||
                b4.out_data !== 8'(8'h10 + k % 4)) begin
                errors++;
                $display("FAIL rr_fair[%0d]: got v=%0b c=%0d d=%h want v=1 c=%0d d=%h",
                         k, b4.out_valid, b4.out_chan, b4.out_data, k % 4, 8'h10 + k % 4);
            end
        end
    endtask

    task automatic test_sparse();
        logic [3:0] exp_rdy;
        int         exp_ch;
        do_reset();
        b4.mode = 1'b1; b4.in_valid = 4'b1010;
        b4.in_data = 32'h23222120; b4.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ch  = (k % 2 == 0) ? 1 : 3;
            exp_rdy = 4'(1 << exp_ch);
            #1;
            checks++;
            if (b4.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sparse_ready[%0d]: got %b want %b", k, b4.in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (b4.out_valid !== 1'b1 || b4.out_chan !== 2'(exp_ch) ||
                b4.out_data !== 8'(8'h20 + exp_ch)) begin
                errors++;
                $display("FAIL sparse_beat[%0d]: got v=%0b c=%0d d=%h want v=1 c=%0d d=%h",
                         k, b4.out_valid, b4.out_chan, b4.out_data, exp_ch, 8'h20 + exp_ch);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        b4.mode = 1'b0; b4.sel = 2'd1; b4.in_valid = 4'b0010;
        b4.in_data = 32'h00003C00; b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b4.sel = 2'($urandom);
            b4.in_data = $urandom;
            b4.in_valid = 4'b1111;
            b4.mode = 1'($urandom);
            #1;
            checks++;
            if (b4.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", k, b4.in_ready);
            end
            tick();
            checks++;
            if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h3C || b4.out_chan !== 2'd1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b d=%h c=%0d want v=1 d=3c c=1",
                         k, b4.out_valid, b4.out_data, b4.out_chan);
            end
        end
        b4.mode = 1'b0; b4.sel = 2'd2; b4.in_data = 32'h005A0000; b4.out_ready = 1'b1;
        #1;
        checks++;
        if (b4.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL drain_ready: got %b want 0100", b4.in_ready);
        end
        tick();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== 8'h5A || b4.out_chan !== 2'd2) begin
            errors++;
            $display("FAIL drain_load: got v=%0b d=%h c=%0d want v=1 d=5a c=2",
                     b4.out_valid, b4.out_data, b4.out_chan);
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] exp_rdy;
        int         exp_ch;
        do_reset();
        b3.mode = 1'b0; b3.sel = 2'd1; b3.in_valid = 3'b111;
        b3.in_data = 24'h332211; b3.out_ready = 1'b1;
        #1;
        checks++;
        if (b3.in_ready !== 3'b010) begin
            errors++;
            $display("FAIL oor_ready_in_range: got %b want 010", b3.in_ready);
        end
        tick();
        checks++;
        if (b3.out_valid !== 1'b1 || b3.out_chan !== 2'd1 || b3.out_data !== 8'h22) begin
            errors++;
            $display("FAIL oor_first_beat: got v=%0b c=%0d d=%h want v=1 c=1 d=22",
                     b3.out_valid, b3.out_chan, b3.out_data);
        end
        b3.sel = 2'd3;
        #1;
        checks++;
        if (b3.in_ready !== 3'b000) begin
            errors++;
            $display("FAIL oor_ready: got %b want 000", b3.in_ready);
        end
        tick();
        checks++;
        if (b3.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_valid: got %0b want 0", b3.out_valid);
        end
        // Pointer sits at 2 after the channel-1 transfer, so wrap shows as 2,0,1.
        b3.mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_ch  = (2 + k) % 3;
            exp_rdy = 3'(1 << exp_ch);
            #1;
            checks++;
            if (b3.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL wrap_ready[%0d]: got %b want %b", k, b3.in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (b3.out_valid !== 1'b1 || b3.out_chan !== 2'(exp_ch) ||
                b3.out_data !== 8'(8'h11 * (exp_ch + 1))) begin
                errors++;
                $display("FAIL wrap_beat[%0d]: got v=%0b c=%0d d=%h want v=1 c=%0d d=%h",
                         k, b3.out_valid, b3.out_chan, b3.out_data, exp_ch,
                         8'h11 * (exp_ch + 1));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_rdy;
        do_reset();
        m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 0;
        b4.mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) b4.mode = ~b4.mode;
            b4.sel       = 2'($urandom);
            b4.in_data   = $urandom;
            b4.in_valid  = 4'($urandom);
            b4.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = m_ready();
            checks++;
            if (b4.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", k, b4.in_ready, exp_rdy);
            end
            model_clock();
            tick();
            checks++;
            if (b4.out_valid !== m_valid || b4.out_data !== m_data ||
                b4.out_chan !== 2'(m_chan)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%0b d=%h c=%0d want v=%0b d=%h c=%0d",
                         k, b4.out_valid, b4.out_data, b4.out_chan, m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b4.mode = 1'b0; b4.sel = '0; b4.in_data = '0; b4.in_valid = '0; b4.out_ready = 1'b0;
        b3.mode = 1'b0; b3.sel = '0; b3.in_data = '0; b3.in_valid = '0; b3.out_ready = 1'b0;
        test_reset();
        test_explicit();
        test_rr_fair();
        test_sparse();
        test_backpressure();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end
endmodule
